time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
- Sequences field-by-field editing of the clock's time and alarm registers.
- Sits between the mode selector (3-bit mode code, 1..4) and the timekeeping datapath.
- Turns set/up/down button levels into field-select, single-cycle inc/dec strobes, auto-repeat and a blink enable for the display.
- Active only in time-set and alarm-set modes; ignores buttons otherwise.

Parameters:
- MODE_TSET, 2, mode code that enables editing of current time (target=0)
- MODE_ASET, 3, mode code that enables editing of alarm (target=1)
- REPEAT_DELAY, 500, ticks an up/down must be held before auto-repeat starts
- REPEAT_RATE, 100, ticks between auto-repeat strobes once repeating
- TIMEOUT, 10000, ticks without any button rising edge before editing aborts
- BLINK_HALF, 250, ticks per blink half-period

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- tick  input  1  1 ms timing pulse, one clk cycle wide
- mode  input  3  current mode code from mode selector
- set_btn  input  1  set button level (debounced, synchronous to clk)
- up  input  1  up button level (debounced, synchronous)
- down  input  1  down button level (debounced, synchronous)
- edit_active  output  1  high while in any edit state
- field_sel  output  2  0 none, 1 hours, 2 minutes, 3 seconds
- target  output  1  0 time registers, 1 alarm registers
- inc  output  1  one-cycle increment strobe to selected field
- dec  output  1  one-cycle decrement strobe to selected field
- blink  output  1  display enable for selected field (1 = visible)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0 except blink=1.
  - Edge-detect registers for set/up/down cleared to 0.
  - All counters cleared.
- Edge detection: a rising edge is registered at a clk edge where the input is sampled 1 and its stored previous sample is 0. All outputs are registered.
- States: IDLE, HOURS, MINUTES, SECONDS. field_sel equals the state encoding (IDLE=0).
- IDLE -> HOURS on set rising edge only when mode is MODE_TSET or MODE_ASET. target is latched from mode at this transition and held until return to IDLE. Other modes: set ignored.
- HOURS -> MINUTES -> SECONDS -> IDLE, one step per set rising edge.
- Any edit state -> IDLE in the next cycle if mode differs from the mode latched at entry. This overrides set/up/down in that cycle.
- Timeout counter:
  - Cleared on any button rising edge and on every state change.
  - Incremented on each tick while editing.
  - On reaching TIMEOUT -> IDLE.
- inc/dec:
  - Only in edit states. inc=1 for exactly one cycle starting at the clk edge that detects an up rising edge; same for dec with down.
  - up and down both high in the same cycle: neither strobe, and the repeat counter is cleared.
  - set rising edge in the same cycle as up/down edge: state advance wins, no strobe.
- Auto-repeat:
  - While exactly one of up/down is held, a hold counter counts ticks.
  - At REPEAT_DELAY ticks the first repeat strobe fires, then one every REPEAT_RATE ticks while still held.
  - Release, or entering/leaving a state, clears the counter.
  - Repeat strobes do not clear the timeout; only rising edges do.
- Blink:
  - In edit states, toggles every BLINK_HALF ticks and is forced to 1 on entry to each field and on every inc/dec strobe.
  - In IDLE, held at 1.
- Counter widths sized to hold max(TIMEOUT, REPEAT_DELAY) with no wrap; counters saturate and never wrap.
- edit_active = (state != IDLE), registered alongside state.

Decomposition:
- Shared package holds:
  - mode codes (IDLE/TIME/TSET/ASET/STOPWATCH values 0..4), also used by the mode selector;
  - field encodings (FIELD_NONE, FIELD_HH, FIELD_MM, FIELD_SS);
  - the edit-state enumeration.
- One sub-module is natural: btn_repeat. It takes level, tick and clear, and produces the rising-edge strobe plus auto-repeat strobes. It is instantiated twice, for up and down.
- The FSM, timeout and blink logic stay in the top level.

Test Plan:
- Reset asserted mid-edit (state MINUTES): outputs return to IDLE values immediately without waiting for clk; blink=1, field_sel=0.
- mode=2, set pulse x4 -> field_sel 1,2,3,0; target=0; edit_active falls on the 4th edge. Repeat with mode=3 -> target=1.
- mode=1 (or 4), set pulse -> stays IDLE. mode=2, HOURS, up pulse -> exactly one inc cycle. up held 800 ticks -> 1 edge strobe + 4 repeat strobes (at 500,600,700,800).
- HOURS, up and down raised together -> no inc/dec. Set and up rise same cycle -> MINUTES, no inc.
- MINUTES, mode changes 2->1 -> IDLE next cycle. Separately, no buttons for 10000 ticks -> IDLE on the 10000th tick.
- HOURS, idle 250 ticks -> blink 1->0. A dec strobe forces blink=1 and restarts the half-period.

Source files
------------

// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the time/alarm set controller and the mode selector.
// Holds the mode codes, the field encodings driven on field_sel, the edit-state
// enumeration (whose encoding equals the field encoding) and a width helper.
package time_set_controller_pkg;

    typedef enum logic [2:0] {
        ModeIdle      = 3'd0,
        ModeTime      = 3'd1,
        ModeTset      = 3'd2,
        ModeAset      = 3'd3,
        ModeStopwatch = 3'd4
    } mode_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HH   = 2'd1;
    localparam logic [1:0] FIELD_MM   = 2'd2;
    localparam logic [1:0] FIELD_SS   = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = FIELD_NONE,
        StHours   = FIELD_HH,
        StMinutes = FIELD_MM,
        StSeconds = FIELD_SS
    } edit_state_e;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Bus between the button/mode side and the time-set controller.
// i_*: tick, mode code, set/up/down levels (driven by master).
// o_*: edit_active, field_sel, target, inc, dec, blink (driven by slave).
interface time_set_controller_if;
    logic       i_tick;
    logic [2:0] i_mode;
    logic       i_set_btn;
    logic       i_up;
    logic       i_down;
    logic       o_edit_active;
    logic [1:0] o_field_sel;
    logic       o_target;
    logic       o_inc;
    logic       o_dec;
    logic       o_blink;

    modport master (
        output i_tick, i_mode, i_set_btn, i_up, i_down,
        input  o_edit_active, o_field_sel, o_target, o_inc, o_dec, o_blink
    );

    modport slave (
        input  i_tick, i_mode, i_set_btn, i_up, i_down,
        output o_edit_active, o_field_sel, o_target, o_inc, o_dec, o_blink
    );
endinterface

// File: rtl/time_set_controller_btn_repeat.sv
// Rising-edge detector plus auto-repeat for one up/down button.
// Ports: clk, rst (async, active-high), i_level (button level), i_tick (1 ms pulse),
// i_clear (suppress strobes and restart the hold count), o_rise (raw rising edge,
// unaffected by i_clear), o_strobe (edge or repeat strobe, combinational).
module time_set_controller_btn_repeat
    import time_set_controller_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    input  logic i_tick,
    input  logic i_clear,
    output logic o_rise,
    output logic o_strobe
);
    localparam int unsigned CNT_MAX = REPEAT_DELAY + REPEAT_RATE - 1;
    localparam int unsigned CW      = cnt_width(CNT_MAX);

    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_fire;

    assign o_rise = i_level & ~r_prev;

    // After the first repeat the count parks at REPEAT_DELAY and runs up to
    // CNT_MAX, so it never exceeds CNT_MAX and never wraps.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_fire    = 1'b0;
        if (i_clear || !i_level) begin
            w_cnt_nxt = '0;
        end else if (i_tick) begin
            if (r_cnt == CW'(REPEAT_DELAY - 1) || r_cnt == CW'(CNT_MAX)) begin
                w_fire    = 1'b1;
                w_cnt_nxt = CW'(REPEAT_DELAY);
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign o_strobe = !i_clear && (o_rise || w_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_level;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Field-by-field editor for time and alarm registers.
// Ports: clk, rst (async, active-high), bus (slave): tick/mode/set/up/down in;
// edit_active, field_sel, target, inc/dec strobes and blink out, all registered.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter logic [2:0]  MODE_TSET    = ModeTset,
    parameter logic [2:0]  MODE_ASET    = ModeAset,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned TIMEOUT      = 10000,
    parameter int unsigned BLINK_HALF   = 250
) (
    input logic                  clk,
    input logic                  rst,
    time_set_controller_if.slave bus
);
    localparam int unsigned TW = cnt_width(TIMEOUT);
    localparam int unsigned BW = cnt_width(BLINK_HALF);

    edit_state_e r_state;
    edit_state_e w_state_nxt;
    logic [2:0]  r_mode;
    logic        r_set_prev;
    logic        r_target;
    logic        r_inc;
    logic        r_dec;
    logic        r_blink;
    logic        r_edit_active;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nxt;
    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_cnt_nxt;
    logic        w_blink_nxt;
    logic        w_target_nxt;
    logic        w_set_rise;
    logic        w_up_rise;
    logic        w_dn_rise;
    logic        w_up_strobe;
    logic        w_dn_strobe;
    logic        w_editing;
    logic        w_mode_ok;
    logic        w_any_rise;
    logic        w_to_expire;
    logic        w_change;
    logic        w_rep_clear;

    assign w_editing   = (r_state != StIdle);
    assign w_set_rise  = bus.i_set_btn & ~r_set_prev;
    assign w_mode_ok   = (bus.i_mode == MODE_TSET) || (bus.i_mode == MODE_ASET);
    assign w_any_rise  = w_set_rise | w_up_rise | w_dn_rise;
    assign w_to_expire = w_editing && bus.i_tick && !w_any_rise &&
                         (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_change    = (w_state_nxt != r_state);
    // State changes, IDLE and both-buttons-held all suppress strobes and restart holds.
    assign w_rep_clear = !w_editing || w_change || (bus.i_up && bus.i_down);

    time_set_controller_btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_up (
        .clk      (clk),
        .rst      (rst),
        .i_level  (bus.i_up),
        .i_tick   (bus.i_tick),
        .i_clear  (w_rep_clear),
        .o_rise   (w_up_rise),
        .o_strobe (w_up_strobe)
    );

    time_set_controller_btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_dn (
        .clk      (clk),
        .rst      (rst),
        .i_level  (bus.i_down),
        .i_tick   (bus.i_tick),
        .i_clear  (w_rep_clear),
        .o_rise   (w_dn_rise),
        .o_strobe (w_dn_strobe)
    );

    // Mode mismatch beats set, set beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_set_rise && w_mode_ok) w_state_nxt = StHours;
            end
            StHours, StMinutes, StSeconds: begin
                if (bus.i_mode != r_mode) begin
                    w_state_nxt = StIdle;
                end else if (w_set_rise) begin
                    w_state_nxt = (r_state == StSeconds) ? StIdle
                                                         : edit_state_e'(r_state + 2'd1);
                end else if (w_to_expire) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_to_cnt_nxt = r_to_cnt;
        if (!w_editing || w_change || w_any_rise) begin
            w_to_cnt_nxt = '0;
        end else if (bus.i_tick && (r_to_cnt < TW'(TIMEOUT))) begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_blink_nxt     = r_blink;
        w_blink_cnt_nxt = r_blink_cnt;
        if (w_state_nxt == StIdle || w_change || w_up_strobe || w_dn_strobe) begin
            w_blink_nxt     = 1'b1;
            w_blink_cnt_nxt = '0;
        end else if (bus.i_tick) begin
            if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
                w_blink_nxt     = ~r_blink;
                w_blink_cnt_nxt = '0;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_target_nxt = r_target;
        if (w_state_nxt == StIdle) begin
            w_target_nxt = 1'b0;
        end else if (!w_editing) begin
            w_target_nxt = (bus.i_mode == MODE_ASET);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_mode        <= '0;
            r_set_prev    <= 1'b0;
            r_target      <= 1'b0;
            r_inc         <= 1'b0;
            r_dec         <= 1'b0;
            r_blink       <= 1'b1;
            r_edit_active <= 1'b0;
            r_to_cnt      <= '0;
            r_blink_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            // Tracks the mode while idle so it holds the entry mode during editing.
            if (!w_editing) r_mode <= bus.i_mode;
            r_set_prev    <= bus.i_set_btn;
            r_target      <= w_target_nxt;
            r_inc         <= w_up_strobe;
            r_dec         <= w_dn_strobe;
            r_blink       <= w_blink_nxt;
            r_edit_active <= (w_state_nxt != StIdle);
            r_to_cnt      <= w_to_cnt_nxt;
            r_blink_cnt   <= w_blink_cnt_nxt;
        end
    end

    assign bus.o_edit_active = r_edit_active;
    assign bus.o_field_sel   = r_state;
    assign bus.o_target      = r_target;
    assign bus.o_inc         = r_inc;
    assign bus.o_dec         = r_dec;
    assign bus.o_blink       = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: directed scenarios plus random stimulus,
// each cycle's expected outputs come from a behavioural model and are checked by a monitor.
module tb_time_set_controller;
    localparam int unsigned DELAY = 500;
    localparam int unsigned RATE  = 100;
    localparam int unsigned TMO   = 10000;
    localparam int unsigned HALF  = 250;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    time_set_controller_if bus();

    time_set_controller #(
        .MODE_TSET    (3'd2),
        .MODE_ASET    (3'd3),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE),
        .TIMEOUT      (TMO),
        .BLINK_HALF   (HALF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       ea;
        logic [1:0] fs;
        logic       tg;
        logic       inc;
        logic       dec;
        logic       bl;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    failures = 0;
    int    obs_inc  = 0;
    string phase    = "reset";

    logic       s_set = 1'b0;
    logic       s_up  = 1'b0;
    logic       s_dn  = 1'b0;
    logic [2:0] s_mode = 3'd1;

    // Model state: field 0..3, latched mode, previous levels, tick counts since events.
    int m_field, m_lmode, idle_ticks, hold_up, hold_dn, blink_ticks;
    bit m_target, m_blink, p_set, p_up, p_dn;

    function automatic void model_reset();
        m_field = 0; m_lmode = 0; idle_ticks = 0; hold_up = 0; hold_dn = 0;
        blink_ticks = 0; m_target = 0; m_blink = 1; p_set = 0; p_up = 0; p_dn = 0;
    endfunction

    function automatic bit rep_fire(input int h);
        return (h >= int'(DELAY)) && ((h - int'(DELAY)) % int'(RATE) == 0);
    endfunction

    task automatic model_step(input bit st, input bit up, input bit dn, input bit tk,
                              input int md);
        bit sr, ur, dr, editing, changed, quiet, ei, ed;
        int nf;
        exp_t e;
        sr = st && !p_set; ur = up && !p_up; dr = dn && !p_dn;
        p_set = st; p_up = up; p_dn = dn;
        editing = (m_field != 0);
        nf = m_field;
        if (!editing) begin
            if (sr && (md == 2 || md == 3)) nf = 1;
        end else if (md != m_lmode) nf = 0;
        else if (sr) nf = (m_field + 1) % 4;
        else if (!ur && !dr && tk && idle_ticks + 1 >= int'(TMO)) nf = 0;
        changed = (nf != m_field);
        if (!editing || changed || sr || ur || dr) idle_ticks = 0;
        else if (tk) idle_ticks++;
        ei = 0; ed = 0;
        quiet = !editing || changed || (up && dn);
        if (quiet) begin
            hold_up = 0; hold_dn = 0;
        end else begin
            if (!up) hold_up = 0;
            else begin
                if (tk) hold_up++;
                ei = ur || (tk && rep_fire(hold_up));
            end
            if (!dn) hold_dn = 0;
            else begin
                if (tk) hold_dn++;
                ed = dr || (tk && rep_fire(hold_dn));
            end
        end
        if (nf == 0 || changed || ei || ed) begin
            blink_ticks = 0; m_blink = 1;
        end else if (tk) begin
            blink_ticks++;
            m_blink = ((blink_ticks / int'(HALF)) % 2) == 0;
        end
        if (nf == 0) m_target = 0;
        else if (!editing) begin
            m_target = (md == 3); m_lmode = md;
        end
        m_field = nf;
        e.ea = (nf != 0); e.fs = 2'(nf); e.tg = m_target;
        e.inc = ei; e.dec = ed; e.bl = m_blink;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge after stimulus.
    always @(posedge clk) begin
        #1;
        if (bus.o_inc === 1'b1) obs_inc++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.o_edit_active !== mon_e.ea || bus.o_field_sel !== mon_e.fs ||
                (mon_e.ea && bus.o_target !== mon_e.tg) || bus.o_inc !== mon_e.inc ||
                bus.o_dec !== mon_e.dec || bus.o_blink !== mon_e.bl) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL %s t=%0t got ea=%b fs=%0d tg=%b inc=%b dec=%b bl=%b want ea=%b fs=%0d tg=%b inc=%b dec=%b bl=%b",
                             phase, $time, bus.o_edit_active, bus.o_field_sel, bus.o_target,
                             bus.o_inc, bus.o_dec, bus.o_blink, mon_e.ea, mon_e.fs, mon_e.tg,
                             mon_e.inc, mon_e.dec, mon_e.bl);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_edit_active"}, int'(bus.o_edit_active), 0);
        chk({name, "_field_sel"}, int'(bus.o_field_sel), 0);
        chk({name, "_inc_dec"}, int'({bus.o_inc, bus.o_dec}), 0);
        chk({name, "_blink"}, int'(bus.o_blink), 1);
    endtask

    task automatic cyc(input bit t);
        @(negedge clk);
        rst           = 1'b0;
        bus.i_tick    = t;
        bus.i_set_btn = s_set;
        bus.i_up      = s_up;
        bus.i_down    = s_dn;
        bus.i_mode    = s_mode;
        model_step(s_set, s_up, s_dn, t, int'(s_mode));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_set();
        s_set = 1'b1; cyc(1'b0);
        s_set = 1'b0; cyc(1'b0);
    endtask

    initial begin
        bus.i_tick = 1'b0; bus.i_mode = 3'd1; bus.i_set_btn = 1'b0;
        bus.i_up = 1'b0; bus.i_down = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 chk_idle("reset");

        phase = "tset_walk";
        s_mode = 3'd2;
        for (int k = 0; k < 4; k++) pulse_set();
        phase = "aset_walk";
        s_mode = 3'd3;
        pulse_set();
        settle(); chk("aset_target", int'(bus.o_target), 1);
        for (int k = 0; k < 3; k++) pulse_set();

        phase = "other_modes";
        s_mode = 3'd1; pulse_set();
        s_mode = 3'd4; pulse_set();
        settle(); chk("mode4_stays_idle", int'(bus.o_edit_active), 0);

        phase = "up_pulse";
        s_mode = 3'd2; pulse_set();
        s_up = 1'b1; cyc(1'b0);
        settle(); chk("up_pulse_inc", int'(bus.o_inc), 1);
        s_up = 1'b0; cyc(1'b0);
        settle(); chk("up_pulse_inc_drop", int'(bus.o_inc), 0);

        phase = "up_hold";
        obs_inc = 0;
        s_up = 1'b1; ticks(800);
        s_up = 1'b0; cyc(1'b0);
        settle(); chk("hold_800_strobes", obs_inc, 5);

        phase = "both_and_set";
        s_up = 1'b1; s_dn = 1'b1; cyc(1'b0);
        settle(); chk("both_no_strobe", int'({bus.o_inc, bus.o_dec}), 0);
        s_up = 1'b0; s_dn = 1'b0; cyc(1'b0);
        s_set = 1'b1; s_up = 1'b1; cyc(1'b0);
        settle(); chk("set_up_field", int'(bus.o_field_sel), 2);
        chk("set_up_no_inc", int'(bus.o_inc), 0);
        s_set = 1'b0; s_up = 1'b0; cyc(1'b0);
        phase = "mode_change";
        s_mode = 3'd1; cyc(1'b0);
        settle(); chk("mode_change_idle", int'(bus.o_edit_active), 0);

        phase = "timeout";
        s_mode = 3'd2; pulse_set();
        ticks(int'(TMO) - 1);
        settle(); chk("timeout_before", int'(bus.o_edit_active), 1);
        ticks(1);
        settle(); chk("timeout_at", int'(bus.o_edit_active), 0);

        phase = "blink";
        pulse_set();
        ticks(int'(HALF) - 1);
        settle(); chk("blink_before_half", int'(bus.o_blink), 1);
        ticks(1);
        settle(); chk("blink_half", int'(bus.o_blink), 0);
        ticks(50);
        s_dn = 1'b1; cyc(1'b0);
        settle(); chk("dec_strobe", int'(bus.o_dec), 1);
        chk("dec_forces_blink", int'(bus.o_blink), 1);
        s_dn = 1'b0; ticks(int'(HALF) - 1);
        settle(); chk("blink_restart_before", int'(bus.o_blink), 1);
        ticks(1);
        settle(); chk("blink_restart_half", int'(bus.o_blink), 0);

        phase = "reset_mid_edit";
        pulse_set();
        settle(); chk("pre_reset_minutes", int'(bus.o_field_sel), 2);
        #1 rst = 1'b1;
        #1 chk_idle("reset_mid");
        s_set = 1'b0; s_up = 1'b0; s_dn = 1'b0;
        model_reset();

        phase = "random";
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 39) == 0) s_set = ~s_set;
            if ($urandom_range(0, 59) == 0) s_up = ~s_up;
            if ($urandom_range(0, 79) == 0) s_dn = ~s_dn;
            if ($urandom_range(0, 399) == 0) begin
                case ($urandom_range(0, 5))
                    0:       s_mode = 3'd1;
                    1, 2:    s_mode = 3'd2;
                    3, 4:    s_mode = 3'd3;
                    default: s_mode = 3'd4;
                endcase
            end
            cyc(1'($urandom_range(0, 2) == 0));
        end
        cyc(1'b0);
        settle();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
